// File: rtl/intr_pkg.sv
// Shared state encoding and stack segment tags for the interrupt entry sequencer.
package intr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_PUSH_PCH = 3'd2,
    ST_PUSH_PCL = 3'd3,
    ST_PUSH_FLG = 3'd4,
    ST_RD_VH    = 3'd5,
    ST_RD_VL    = 3'd6,
    ST_LOAD     = 3'd7
  } intr_state_e;

  localparam logic [1:0] SEG_NONE = 2'b00;
  localparam logic [1:0] SEG_PCH  = 2'b10;
  localparam logic [1:0] SEG_PCL  = 2'b11;
  localparam logic [1:0] SEG_FLG  = 2'b01;

endpackage

// File: rtl/intr_controller.sv
// Interrupt entry sequencer: flush, push PC (and flags when INTR_FLAGS_PUSH_EN is defined),
// fetch the two-word vector, load the handler PC. One request can be held pending while busy.
module intr_controller
  import intr_pkg::*;
#(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(12'h002)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr_req,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        flags_in,
  input  logic              mem_stall,
  input  logic [15:0]       mem_rdata,
  output logic              nop,
  output logic              push,
  output logic [15:0]       push_data,
  output logic [1:0]        push_seg,
  output logic              flags_clr,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              write_pc,
  output logic [31:0]       pc_out,
  output logic              busy,
  output logic              int_ack
);

  // Low vector word address; the ADDR_W-wide sum wraps at the top of memory.
  localparam logic [ADDR_W-1:0] VEC_ADDR_LO = VEC_ADDR + 1'b1;

  intr_state_e r_state;
  logic [31:0] r_pc_save;
  logic [15:0] r_vec_hi;
  logic        r_pend;
`ifdef INTR_FLAGS_PUSH_EN
  logic [3:0]  r_flg_save;
`endif

  logic w_strobe_ok;
  assign w_strobe_ok = ~mem_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pc_save  <= '0;
      r_vec_hi   <= '0;
      r_pend     <= 1'b0;
`ifdef INTR_FLAGS_PUSH_EN
      r_flg_save <= '0;
`endif
    end else begin
      if (r_state != ST_IDLE && intr_req) r_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (intr_req || r_pend) begin
            r_pc_save  <= pc_in;
`ifdef INTR_FLAGS_PUSH_EN
            r_flg_save <= flags_in;
`endif
            r_pend     <= 1'b0;
            r_state    <= ST_FLUSH;
          end
        end
        ST_FLUSH:    r_state <= ST_PUSH_PCH;
        ST_PUSH_PCH: if (!mem_stall) r_state <= ST_PUSH_PCL;
`ifdef INTR_FLAGS_PUSH_EN
        ST_PUSH_PCL: if (!mem_stall) r_state <= ST_PUSH_FLG;
`else
        ST_PUSH_PCL: if (!mem_stall) r_state <= ST_RD_VH;
`endif
        ST_PUSH_FLG: if (!mem_stall) r_state <= ST_RD_VH;
        ST_RD_VH:    if (!mem_stall) r_state <= ST_RD_VL;
        ST_RD_VL: begin
          if (!mem_stall) begin
            r_vec_hi <= mem_rdata;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD:     if (!mem_stall) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nop       = (r_state != ST_IDLE);
    busy      = (r_state != ST_IDLE);
    push      = 1'b0;
    push_data = '0;
    push_seg  = SEG_NONE;
    flags_clr = 1'b0;
    vec_rd    = 1'b0;
    vec_addr  = '0;
    write_pc  = 1'b0;
    pc_out    = '0;
    int_ack   = 1'b0;
    case (r_state)
      ST_PUSH_PCH: begin
        push      = w_strobe_ok;
        push_seg  = SEG_PCH;
        push_data = r_pc_save[31:16];
      end
      ST_PUSH_PCL: begin
        push      = w_strobe_ok;
        push_seg  = SEG_PCL;
        push_data = r_pc_save[15:0];
      end
`ifdef INTR_FLAGS_PUSH_EN
      ST_PUSH_FLG: begin
        push      = w_strobe_ok;
        push_seg  = SEG_FLG;
        push_data = {12'b0, r_flg_save};
        flags_clr = 1'b1;
      end
`endif
      ST_RD_VH: begin
        vec_rd   = w_strobe_ok;
        vec_addr = VEC_ADDR;
      end
      ST_RD_VL: begin
        vec_rd   = w_strobe_ok;
        vec_addr = VEC_ADDR_LO;
      end
      ST_LOAD: begin
        write_pc = w_strobe_ok;
        int_ack  = w_strobe_ok;
        pc_out   = {r_vec_hi, mem_rdata};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_controller.sv
// Directed-plus-random bench for intr_controller; expectations come from the sequence
// timeline (push words, latency, vector fetch) computed from pc/flags/stall inputs.
module tb_intr_controller;
  import intr_pkg::*;

`ifdef INTR_FLAGS_PUSH_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif
  localparam int BASE_LAT = FLG ? 7 : 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr_req;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        mem_stall;
  logic [15:0] mem_rdata;
  logic [15:0] w_mem_rdata;

  logic        nop, push, flags_clr, vec_rd, write_pc, busy, int_ack;
  logic [15:0] push_data;
  logic [1:0]  push_seg;
  logic [11:0] vec_addr;
  logic [31:0] pc_out;

  logic        w_nop, w_push, w_flags_clr, w_vec_rd, w_write_pc, w_busy, w_int_ack;
  logic [15:0] w_push_data;
  logic [1:0]  w_push_seg;
  logic [11:0] w_vec_addr;
  logic [31:0] w_pc_out;

  logic [15:0] mem [0:4095];
  logic [17:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  intr_controller u_dut (
    .clk(clk), .rst(rst), .intr_req(intr_req), .pc_in(pc_in), .flags_in(flags_in),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .nop(nop), .push(push),
    .push_data(push_data), .push_seg(push_seg), .flags_clr(flags_clr), .vec_rd(vec_rd),
    .vec_addr(vec_addr), .write_pc(write_pc), .pc_out(pc_out), .busy(busy), .int_ack(int_ack)
  );

  intr_controller #(.ADDR_W(12), .VEC_ADDR(12'hFFF)) u_wrap (
    .clk(clk), .rst(rst), .intr_req(intr_req), .pc_in(pc_in), .flags_in(flags_in),
    .mem_stall(mem_stall), .mem_rdata(w_mem_rdata), .nop(w_nop), .push(w_push),
    .push_data(w_push_data), .push_seg(w_push_seg), .flags_clr(w_flags_clr),
    .vec_rd(w_vec_rd), .vec_addr(w_vec_addr), .write_pc(w_write_pc), .pc_out(w_pc_out),
    .busy(w_busy), .int_ack(w_int_ack)
  );

  // Data memory: read data appears the cycle after the strobe and holds otherwise.
  always @(posedge clk) begin
    if (vec_rd)   mem_rdata   <= mem[vec_addr];
    if (w_vec_rd) w_mem_rdata <= mem[w_vec_addr];
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete entry sequence. Cycle c counts clock periods after the capturing edge.
  task automatic run_seq(input logic [31:0] pc, input logic [3:0] flg, input int stall,
                         input int pulses, input bit start_req);
    int          lat;
    bit          exp_push;
    logic [17:0] got;
    logic [31:0] exp_pc, exp_wrap_pc;
    lat = BASE_LAT + stall;
    exp_q.delete();
    exp_q.push_back({2'b10, pc[31:16]});
    exp_q.push_back({2'b11, pc[15:0]});
    if (FLG) exp_q.push_back({2'b01, 12'h000, flg});
    exp_pc      = {mem[12'h002], mem[12'h003]};
    exp_wrap_pc = {mem[12'hFFF], mem[12'h000]};
    pc_in    = pc;
    flags_in = flg;
    intr_req = start_req;
    step();
    intr_req = 1'b0;
    pc_in    = $urandom;
    flags_in = 4'($urandom_range(0, 15));
    for (int c = 1; c <= lat; c++) begin
      mem_stall = (c >= 3 && c < 3 + stall);
      intr_req  = (pulses > 0 && c == lat - 2) || (pulses > 1 && c == lat);
      #1;
      chk("busy", 32'(busy), 32'd1);
      chk("nop", 32'(nop), 32'd1);
      exp_push = (c == 2) || (c == 3 + stall) || (FLG && c == 4 + stall);
      chk("push", 32'(push), 32'(exp_push));
      if (push && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("push_word", 32'({push_seg, push_data}), 32'(got));
      end
      chk("flags_clr", 32'(flags_clr), 32'(FLG && c == 4 + stall));
      chk("vec_rd", 32'(vec_rd), 32'(c == lat - 2 || c == lat - 1));
      if (c == lat - 2) chk("vec_addr_hi", 32'(vec_addr), 32'h002);
      if (c == lat - 1) chk("vec_addr_lo", 32'(vec_addr), 32'h003);
      if (c == lat - 1) chk("wrap_vec_addr", 32'(w_vec_addr), 32'h000);
      chk("write_pc", 32'(write_pc), 32'(c == lat));
      chk("int_ack", 32'(int_ack), 32'(c == lat));
      if (c == lat) begin
        chk("pc_out", pc_out, exp_pc);
        chk("wrap_pc_out", w_pc_out, exp_wrap_pc);
      end
      step();
    end
    mem_stall = 1'b0;
    intr_req  = 1'b0;
    #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("nop_end", 32'(nop), 32'd0);
    chk("pushes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rst = 1'b0; intr_req = 1'b0; pc_in = '0; flags_in = '0; mem_stall = 1'b0;
    // Requests during reset must be ignored.
    @(negedge clk);
    intr_req = 1'b1;
    step();
    step();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nop", 32'(nop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_write_pc", 32'(write_pc), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    intr_req = 1'b0;
    rst = 1'b1;
    step();

    // Directed single interrupt with known vector words.
    mem[2] = 16'h0000;
    mem[3] = 16'h0100;
    run_seq(32'h0000_1234, 4'b1010, 0, 0, 1'b1);

    // Three-cycle stall while pushing the PC low word.
    run_seq($urandom, 4'($urandom_range(0, 15)), 3, 0, 1'b1);

    // Back-to-back: one pending request taken, a further one dropped.
    run_seq($urandom, 4'($urandom_range(0, 15)), 0, 2, 1'b1);
    run_seq($urandom, 4'($urandom_range(0, 15)), 0, 0, 1'b0);
    step();
    #1;
    chk("no_third_seq", 32'(busy), 32'd0);

    // Reset while pushing the PC low word, with a request pending.
    pc_in = $urandom;
    intr_req = 1'b1;
    step();
    intr_req = 1'b0;
    step();
    intr_req = 1'b1;
    step();
    intr_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_push", 32'(push), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("abort_idle_busy", 32'(busy), 32'd0);
      chk("abort_idle_wpc", 32'(write_pc), 32'd0);
    end
    run_seq($urandom, 4'($urandom_range(0, 15)), 0, 0, 1'b1);

    // Randomized sequences with random stalls and idle gaps.
    for (int n = 0; n < 12; n++) begin
      mem[2] = 16'($urandom);
      mem[3] = 16'($urandom);
      run_seq($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 0, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 Parameter VEC_ADDR, default 12'h002: data-memory address of the interrupt-vector high word; the low word is at VEC_ADDR+1.
REQ-002 Parameter ADDR_W, default 12: data-memory address width.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 at a rising edge resets).
REQ-005 intr_req  input  1  interrupt request from the return/interrupt sequencer; level-sampled.
REQ-006 pc_in  input  32  address of the next instruction to resume after the handler.
REQ-007 flags_in  input  4  CCR flags to preserve.
REQ-008 mem_stall  input  1  memory busy; holds the FSM when high.
REQ-009 mem_rdata  input  16  data-memory read data, valid one cycle after vec_rd.
REQ-010 nop  output  1  inserts a bubble into the fetch/decode stages.
REQ-011 push  output  1  stack write strobe.
REQ-012 push_data  output  16  word to push.
REQ-013 push_seg  output  2  segment tag: 00 none, 10 PC high, 11 PC low, 01 flags.
REQ-014 flags_clr  output  1  clears the CCR.
REQ-015 vec_rd  output  1  data-memory read strobe.
REQ-016 vec_addr  output  ADDR_W  read address.
REQ-017 write_pc  output  1  loads pc_out into the PC.
REQ-018 pc_out  output  32  handler address.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 int_ack  output  1  one-cycle pulse when the handler PC is loaded.

Function
REQ-021 States: IDLE, FLUSH, PUSH_PCH, PUSH_PCL, PUSH_FLG, RD_VH, RD_VL, LOAD; all outputs are decoded from the registered state and are zero unless stated otherwise.
REQ-022 In IDLE with intr_req=1, the FSM captures pc_in into pc_save and flags_in into flg_save at the edge, then enters FLUSH.
REQ-023 FLUSH: nop=1, then go to PUSH_PCH.
REQ-024 PUSH_PCH: push=1, push_seg=10, push_data=pc_save[31:16]; PUSH_PCL: push=1, push_seg=11, push_data=pc_save[15:0].
REQ-025 PUSH_FLG: push=1, push_seg=01, push_data={12'b0,flg_save}, flags_clr=1.
REQ-026 RD_VH: vec_rd=1, vec_addr=VEC_ADDR. RD_VL: vec_rd=1, vec_addr=VEC_ADDR+1; mem_rdata is captured into vec_hi.
REQ-027 LOAD: write_pc=1, pc_out={vec_hi,mem_rdata}, int_ack=1, then go to IDLE.
REQ-028 nop SHALL be held at 1 from FLUSH through LOAD inclusive.
REQ-029 Latency: if intr_req is sampled at edge E0, write_pc SHALL be high in the 7th cycle after E0 (6th without the flags push), provided there are no stalls.
REQ-030 When mem_stall=1 in any state other than IDLE or FLUSH, the state and captured registers hold and the strobes push, vec_rd and write_pc SHALL be forced low.
REQ-031 An intr_req arriving while busy sets a one-deep pending bit; further requests are dropped.
REQ-032 On leaving LOAD, a set pending bit SHALL be treated as intr_req in IDLE (captured at the next edge) and then cleared.
REQ-033 vec_addr SHALL wrap modulo 2^ADDR_W.

Reset
REQ-034 When rst=0, the FSM enters IDLE; pc_save, flg_save, vec_hi and pending clear; all outputs are 0 in the next cycle.
REQ-035 A reset mid-sequence SHALL abort the sequence with no further push or write_pc; partially pushed words are not undone.

Configuration
REQ-036 Macro INTR_FLAGS_PUSH_EN: when defined, PUSH_FLG exists as in REQ-025.
REQ-037 When INTR_FLAGS_PUSH_EN is undefined, PUSH_PCL goes directly to RD_VH, flags_clr is tied 0, and push_seg 01 is never produced.

Structure
REQ-038 Shared package intr_pkg SHALL hold the state encoding and the push_seg codes SEG_NONE, SEG_PCH, SEG_PCL and SEG_FLG.
REQ-039 The block is a single module with no sub-modules.

Verification
REQ-040 Single interrupt: pc_in=32'h0000_1234, flags_in=4'b1010, vector words 16'h0000 and 16'h0100 -> push data 0000, 1234, 000A with tags 10, 11, 01; write_pc with pc_out=32'h0000_0100 seven cycles after E0.
REQ-041 Stall: mem_stall=1 for 3 cycles in PUSH_PCL -> push is low during those cycles, the sequence resumes, and write_pc occurs at E0+10.
REQ-042 Back-to-back: intr_req pulsed again during RD_VH -> a second full sequence starts after LOAD; a third pulse during the same window is ignored.
REQ-043 Reset at PUSH_PCL -> busy=0 and no write_pc; a new intr_req afterwards produces a clean sequence.
REQ-044 Without INTR_FLAGS_PUSH_EN: only 2 pushes, and write_pc occurs at E0+6.
REQ-045 VEC_ADDR=12'hFFF -> the second read uses address 12'h000.
